// File: rtl/gopigo_cmd_pkg.sv
// Shared constants for the GoPiGo3 command scheduler: slot map, message types,
// port/LED ids and per-slot frame lengths.
package gopigo_cmd_pkg;

   localparam int NUM_SLOTS   = 9;
   localparam int FRAME_BYTES = 6;

   localparam logic [3:0] SLOT_PWM_L     = 4'd0;
   localparam logic [3:0] SLOT_PWM_R     = 4'd1;
   localparam logic [3:0] SLOT_DPS_LIMIT = 4'd2;
   localparam logic [3:0] SLOT_DPS_L     = 4'd3;
   localparam logic [3:0] SLOT_DPS_R     = 4'd4;
   localparam logic [3:0] SLOT_EYE_L     = 4'd5;
   localparam logic [3:0] SLOT_EYE_R     = 4'd6;
   localparam logic [3:0] SLOT_BLINK_L   = 4'd7;
   localparam logic [3:0] SLOT_BLINK_R   = 4'd8;

   localparam logic [7:0] MSG_LED   = 8'h06;
   localparam logic [7:0] MSG_PWM   = 8'h0A;
   localparam logic [7:0] MSG_DPS   = 8'h0E;
   localparam logic [7:0] MSG_LIMIT = 8'h0F;

   localparam logic [7:0] PORT_LEFT  = 8'h01;
   localparam logic [7:0] PORT_RIGHT = 8'h02;
   localparam logic [7:0] PORT_BOTH  = 8'h03;

   localparam logic [7:0] LED_EYE_L   = 8'h02;
   localparam logic [7:0] LED_EYE_R   = 8'h01;
   localparam logic [7:0] LED_BLINK_L = 8'h04;
   localparam logic [7:0] LED_BLINK_R = 8'h08;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } sched_state_t;

   function automatic logic [2:0] frame_len(input logic [3:0] slot);
      case (slot)
         SLOT_PWM_L, SLOT_PWM_R: return 3'd4;
         SLOT_DPS_LIMIT:         return 3'd6;
         SLOT_DPS_L, SLOT_DPS_R: return 3'd5;
         default:                return 3'd6;
      endcase
   endfunction

endpackage

// File: rtl/gopigo_cmd_rr_arbiter.sv
// Round-robin pick of the first pending slot above last_served (mod NUM_SLOTS).
// Purely combinational; no backpressure of its own.
module gopigo_cmd_rr_arbiter
   import gopigo_cmd_pkg::*;
(
   input  logic [NUM_SLOTS-1:0] pending,
   input  logic [3:0]           last_served,
   output logic [NUM_SLOTS-1:0] grant,
   output logic [3:0]           index,
   output logic                 found
);

   logic [4:0] sum;
   logic [4:0] cand;

   always_comb begin
      grant = '0;
      index = '0;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int k = 1; k <= NUM_SLOTS; k++) begin
         sum  = {1'b0, last_served} + 5'(k);
         cand = (sum >= 5'(NUM_SLOTS)) ? sum - 5'(NUM_SLOTS) : sum;
         if (!found && pending[cand[3:0]]) begin
            found = 1'b1;
            index = cand[3:0];
         end
      end
      if (found) begin
         grant[index] = 1'b1;
      end
   end

endmodule

// File: rtl/gopigo_cmd_scheduler.sv
// Change-detecting, round-robin GoPiGo3 SPI command framer; first byte is offered from the launch edge.
// Bytes advance only on byte_ack_i; data/last are held while the engine stalls, and GAP_CYC idle cycles separate frames.
module gopigo_cmd_scheduler
   import gopigo_cmd_pkg::*;
#(
   parameter int unsigned GAP_CYC     = 24,
   parameter int unsigned REFRESH_CYC = 1200000,
   parameter logic [7:0]  SPI_ADDR    = 8'h08
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable_i,
   input  logic [7:0]  motor_pwm_left_i,
   input  logic [7:0]  motor_pwm_rght_i,
   input  logic [15:0] motor_dps_limit_i,
   input  logic [15:0] motor_dps_left_i,
   input  logic [15:0] motor_dps_rght_i,
   input  logic [23:0] led_eye_left_rgb_i,
   input  logic [23:0] led_eye_rght_rgb_i,
   input  logic [23:0] led_blink_left_rgb_i,
   input  logic [23:0] led_blink_rght_rgb_i,
   output logic        byte_valid_o,
   output logic [7:0]  byte_data_o,
   output logic        byte_last_o,
   input  logic        byte_ack_i,
   output logic        busy_o,
   output logic [3:0]  slot_o
);

   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int RW = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

   sched_state_t          state;
   logic [23:0]           cur_val [NUM_SLOTS];
   logic [23:0]           shadow  [NUM_SLOTS];
   logic [NUM_SLOTS-1:0]  force_pend;
   logic [NUM_SLOTS-1:0]  pending;
   logic [NUM_SLOTS-1:0]  grant;
   logic [NUM_SLOTS-1:0]  launch_mask;
   logic [3:0]            grant_idx;
   logic                  found;
   logic                  launch;
   logic                  refresh_hit;
   logic [3:0]            last_served;
   logic [7:0]            frame_buf  [FRAME_BYTES];
   logic [7:0]            next_frame [FRAME_BYTES];
   logic [23:0]           sel_val;
   logic [7:0]            led_id;
   logic [2:0]            byte_idx;
   logic [2:0]            frame_len_q;
   logic [GW-1:0]         gap_cnt;

   always_comb begin
      cur_val[SLOT_PWM_L]     = {16'h0, motor_pwm_left_i};
      cur_val[SLOT_PWM_R]     = {16'h0, motor_pwm_rght_i};
      cur_val[SLOT_DPS_LIMIT] = {8'h0, motor_dps_limit_i};
      cur_val[SLOT_DPS_L]     = {8'h0, motor_dps_left_i};
      cur_val[SLOT_DPS_R]     = {8'h0, motor_dps_rght_i};
      cur_val[SLOT_EYE_L]     = led_eye_left_rgb_i;
      cur_val[SLOT_EYE_R]     = led_eye_rght_rgb_i;
      cur_val[SLOT_BLINK_L]   = led_blink_left_rgb_i;
      cur_val[SLOT_BLINK_R]   = led_blink_rght_rgb_i;
   end

   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         pending[i] = (cur_val[i] != shadow[i]) | force_pend[i];
      end
   end

   gopigo_cmd_rr_arbiter u_arb (
      .pending     (pending),
      .last_served (last_served),
      .grant       (grant),
      .index       (grant_idx),
      .found       (found)
   );

   assign launch      = (state == ST_IDLE) && enable_i && found;
   assign launch_mask = launch ? grant : '0;

   always_comb begin
      led_id = LED_BLINK_R;
      case (grant_idx)
         SLOT_EYE_L:   led_id = LED_EYE_L;
         SLOT_EYE_R:   led_id = LED_EYE_R;
         SLOT_BLINK_L: led_id = LED_BLINK_L;
         default:      led_id = LED_BLINK_R;
      endcase
   end

   // Frame image for the granted slot; unused tail bytes stay zero.
   always_comb begin
      sel_val = cur_val[grant_idx];
      for (int i = 0; i < FRAME_BYTES; i++) begin
         next_frame[i] = 8'h00;
      end
      next_frame[0] = SPI_ADDR;
      case (grant_idx)
         SLOT_PWM_L, SLOT_PWM_R: begin
            next_frame[1] = MSG_PWM;
            next_frame[2] = (grant_idx == SLOT_PWM_L) ? PORT_LEFT : PORT_RIGHT;
            next_frame[3] = sel_val[7:0];
         end
         SLOT_DPS_LIMIT: begin
            next_frame[1] = MSG_LIMIT;
            next_frame[2] = PORT_BOTH;
            next_frame[3] = 8'h00;
            next_frame[4] = sel_val[15:8];
            next_frame[5] = sel_val[7:0];
         end
         SLOT_DPS_L, SLOT_DPS_R: begin
            next_frame[1] = MSG_DPS;
            next_frame[2] = (grant_idx == SLOT_DPS_L) ? PORT_LEFT : PORT_RIGHT;
            next_frame[3] = sel_val[15:8];
            next_frame[4] = sel_val[7:0];
         end
         default: begin
            next_frame[1] = MSG_LED;
            next_frame[2] = led_id;
            next_frame[3] = sel_val[23:16];
            next_frame[4] = sel_val[15:8];
            next_frame[5] = sel_val[7:0];
         end
      endcase
   end

   generate
      if (REFRESH_CYC == 0) begin : g_no_refresh
         assign refresh_hit = 1'b0;
      end else begin : g_refresh
         logic [RW-1:0] rcnt;
         assign refresh_hit = (rcnt == RW'(REFRESH_CYC - 1));
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rcnt <= '0;
            end else if (refresh_hit) begin
               rcnt <= '0;
            end else begin
               rcnt <= rcnt + 1'b1;
            end
         end
      end
   endgenerate

   // A refresh landing on a launch edge wins, so that slot is resent too.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         force_pend <= '1;
      end else begin
         force_pend <= (force_pend & ~launch_mask) | {NUM_SLOTS{refresh_hit}};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         byte_valid_o <= 1'b0;
         byte_data_o  <= 8'h00;
         byte_last_o  <= 1'b0;
         busy_o       <= 1'b0;
         slot_o       <= 4'd0;
         last_served  <= SLOT_BLINK_R;
         byte_idx     <= 3'd0;
         frame_len_q  <= 3'd0;
         gap_cnt      <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            shadow[i] <= 24'h0;
         end
         for (int i = 0; i < FRAME_BYTES; i++) begin
            frame_buf[i] <= 8'h00;
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (launch) begin
                  for (int i = 0; i < FRAME_BYTES; i++) begin
                     frame_buf[i] <= next_frame[i];
                  end
                  shadow[grant_idx] <= cur_val[grant_idx];
                  last_served       <= grant_idx;
                  slot_o            <= grant_idx;
                  byte_idx          <= 3'd0;
                  frame_len_q       <= frame_len(grant_idx);
                  byte_valid_o      <= 1'b1;
                  byte_data_o       <= next_frame[0];
                  byte_last_o       <= 1'b0;
                  busy_o            <= 1'b1;
                  state             <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (byte_valid_o && byte_ack_i) begin
                  if (byte_last_o) begin
                     byte_valid_o <= 1'b0;
                     byte_last_o  <= 1'b0;
                     if (GAP_CYC == 0) begin
                        busy_o <= 1'b0;
                        state  <= ST_IDLE;
                     end else begin
                        gap_cnt <= GW'(GAP_CYC - 1);
                        state   <= ST_GAP;
                     end
                  end else begin
                     byte_idx    <= byte_idx + 3'd1;
                     byte_data_o <= frame_buf[byte_idx + 3'd1];
                     byte_last_o <= ((byte_idx + 3'd1) == (frame_len_q - 3'd1));
                  end
               end
            end
            ST_GAP: begin
               if (gap_cnt == '0) begin
                  busy_o <= 1'b0;
                  state  <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
